// File: rtl/program_loader.sv
// Byte-stream loader: receives a length/word/checksum frame and writes the words
// into instruction memory, holding the CPU in reset until a verified frame lands.
module program_loader #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [7:0]        Rx_Data,
  input  logic              Rx_Valid,
  output logic              Rx_Ready,
  output logic [ADDR_W-1:0] I_addr,
  output logic [15:0]       I_data,
  output logic              I_wr,
  output logic              Cpu_Reset,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [7:0]        Word_Count
);

  localparam int unsigned IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_HI, S_LO, S_WR, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t            r_state;
  logic [8:0]        r_len;
  logic [8:0]        r_idx;
  logic [7:0]        r_hi;
  logic [7:0]        r_xor;
  logic [IDLE_W-1:0] r_idle;

  state_t w_next;
  logic   w_xfer;
  logic   w_timeout;
  logic   w_enter_len;

  function automatic state_t f_next(input state_t s, input logic start, input logic xfer,
                                    input logic tmo, input logic chk_ok, input logic last_word);
    f_next = s;
    case (s)
      S_IDLE, S_DONE, S_ERR: if (start) f_next = S_LEN;
      S_LEN: if (xfer) f_next = S_HI;  else if (tmo) f_next = S_ERR;
      S_HI:  if (xfer) f_next = S_LO;  else if (tmo) f_next = S_ERR;
      S_LO:  if (xfer) f_next = S_WR;  else if (tmo) f_next = S_ERR;
      S_WR:  f_next = last_word ? S_CHK : S_HI;
      S_CHK: if (xfer) f_next = chk_ok ? S_DONE : S_ERR;
             else if (tmo) f_next = S_ERR;
      default: f_next = S_IDLE;
    endcase
  endfunction

  assign w_xfer      = Rx_Valid && Rx_Ready;
  assign w_timeout   = !w_xfer && (r_idle == IDLE_W'(TIMEOUT - 1));
  assign w_next      = f_next(r_state, Start, w_xfer, w_timeout, Rx_Data == r_xor,
                              (r_idx + 9'd1) == r_len);
  assign w_enter_len = (w_next == S_LEN) && (r_state != S_LEN);

  // State, datapath and registered status outputs decoded from the next state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_idx      <= '0;
      r_hi       <= '0;
      r_xor      <= '0;
      r_idle     <= '0;
      Rx_Ready   <= 1'b0;
      I_addr     <= '0;
      I_data     <= '0;
      I_wr       <= 1'b0;
      Cpu_Reset  <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Error      <= 1'b0;
      Word_Count <= '0;
    end else begin
      r_state   <= w_next;
      Rx_Ready  <= (w_next inside {S_LEN, S_HI, S_LO, S_CHK});
      Busy      <= (w_next inside {S_LEN, S_HI, S_LO, S_WR, S_CHK});
      Cpu_Reset <= !(w_next inside {S_IDLE, S_DONE});
      Done      <= (w_next == S_DONE);
      Error     <= (w_next == S_ERR);
      I_wr      <= 1'b0;

      if (w_xfer && r_state != S_CHK) r_xor <= r_xor ^ Rx_Data;

      if (w_enter_len) begin
        r_xor      <= '0;
        r_idle     <= '0;
        Word_Count <= '0;
      end else if (w_xfer) begin
        r_idle <= '0;
      end else if (r_state inside {S_LEN, S_HI, S_LO, S_CHK}) begin
        r_idle <= r_idle + IDLE_W'(1);
      end

      case (r_state)
        S_LEN: if (w_xfer) begin
          r_len <= {Rx_Data == 8'd0, Rx_Data};
          r_idx <= '0;
        end
        S_HI: if (w_xfer) r_hi <= Rx_Data;
        S_LO: if (w_xfer) begin
          I_data <= {r_hi, Rx_Data};
          I_addr <= ADDR_W'(r_idx);
          I_wr   <= 1'b1;
        end
        S_WR: begin
          r_idx      <= r_idx + 9'd1;
          Word_Count <= Word_Count + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: frames are built from the frame rules and
// every memory write and end-of-frame status is compared against that model.
module tb_program_loader;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [7:0]  Rx_Data = 8'h00;
  logic        Rx_Valid = 1'b0;
  logic        Rx_Ready;
  logic [7:0]  I_addr;
  logic [15:0] I_data;
  logic        I_wr;
  logic        Cpu_Reset;
  logic        Busy;
  logic        Done;
  logic        Error;
  logic [7:0]  Word_Count;

  program_loader #(.ADDR_W(8), .TIMEOUT(255)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Rx_Data(Rx_Data), .Rx_Valid(Rx_Valid),
    .Rx_Ready(Rx_Ready), .I_addr(I_addr), .I_data(I_data), .I_wr(I_wr),
    .Cpu_Reset(Cpu_Reset), .Busy(Busy), .Done(Done), .Error(Error), .Word_Count(Word_Count)
  );

  always #5 Clk = ~Clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  tx_q[$];
  logic [23:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Every write strobe must match the oldest outstanding expected {addr,data}.
  always @(negedge Clk) begin
    if (!Reset && I_wr === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_wr", {8'h00, I_addr, I_data}, 32'hFFFF_FFFF);
      else                   check("wr", {8'h00, I_addr, I_data}, {8'h00, exp_q.pop_front()});
    end
  end

  task automatic build_frame(input int n, input bit bad, input bit pat);
    logic [15:0] w;
    logic [7:0]  x;
    tx_q.delete();
    tx_q.push_back(8'(n));
    for (int k = 0; k < n; k++) begin
      w = pat ? {8'(k), ~8'(k)} : 16'($urandom);
      tx_q.push_back(w[15:8]);
      tx_q.push_back(w[7:0]);
      exp_q.push_back({8'(k), w});
    end
    x = 8'h00;
    foreach (tx_q[i]) x = x ^ tx_q[i];
    tx_q.push_back(x ^ 8'(bad));
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
    int c;
    repeat (gap) begin
      @(negedge Clk);
      Rx_Valid = 1'b0;
      Rx_Data  = 8'($urandom);
      Start    = noise & 1'($urandom);
    end
    @(negedge Clk);
    Rx_Valid = 1'b1;
    Rx_Data  = b;
    Start    = noise & 1'($urandom);
    c = 0;
    while (Rx_Ready !== 1'b1 && c < 100) begin
      @(negedge Clk);
      c++;
    end
    if (c >= 100) check("byte_accept", {31'b0, Rx_Ready}, 32'd1);
    @(posedge Clk);
  endtask

  task automatic start_pulse();
    @(negedge Clk);
    Start    = 1'b1;
    Rx_Valid = 1'b0;
    @(negedge Clk);
    Start = 1'b0;
    check("after_start", {27'b0, Rx_Ready, Cpu_Reset, Busy, Done, Error}, 32'b11100);
  endtask

  task automatic run_tx(input int n, input bit ok, input int maxgap, input bit noise);
    start_pulse();
    foreach (tx_q[i])
      send_byte(tx_q[i], (maxgap == 0) ? 0 : $urandom_range(maxgap, 0),
                noise && (i != tx_q.size() - 1));
    @(negedge Clk);
    Rx_Valid = 1'b0;
    Start    = 1'b0;
    check("status", {28'b0, Done, Error, Cpu_Reset, Busy}, {28'b0, ok, !ok, !ok, 1'b0});
    check("word_count", {24'b0, Word_Count}, {24'b0, 8'(n)});
    check("writes_drained", exp_q.size(), 0);
  endtask

  initial begin
    #1;
    check("rst_data", {8'h00, I_addr, I_data}, 0);
    check("rst_flags", {18'b0, Rx_Ready, I_wr, Cpu_Reset, Busy, Done, Error, Word_Count}, 0);
    @(negedge Clk);
    Reset = 1'b0;

    // Reference frame from the worked example, good then bad checksum.
    tx_q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    exp_q = '{{8'h00, 16'h1234}, {8'h01, 16'hABCD}};
    run_tx(2, 1'b1, 0, 1'b0);
    tx_q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
    exp_q = '{{8'h00, 16'h1234}, {8'h01, 16'hABCD}};
    run_tx(2, 1'b0, 0, 1'b0);

    // Timeout: 255 idle cycles after the length byte.
    exp_q.delete();
    start_pulse();
    send_byte(8'h01, 0, 1'b0);
    @(negedge Clk);
    Rx_Valid = 1'b0;
    repeat (254) @(negedge Clk);
    check("pre_timeout", {29'b0, Busy, Error, Cpu_Reset}, 32'b101);
    @(negedge Clk);
    check("timeout", {29'b0, Busy, Error, Cpu_Reset}, 32'b011);

    // Full 256-word frame with length byte 0.
    build_frame(256, 1'b0, 1'b1);
    run_tx(256, 1'b1, 0, 1'b0);

    // Back-to-back bytes across the write bubble.
    build_frame(20, 1'b0, 1'b0);
    run_tx(20, 1'b1, 0, 1'b0);

    // Reset after the third byte, then a clean frame.
    exp_q = '{{8'h00, 16'h1234}};
    start_pulse();
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h12, 0, 1'b0);
    send_byte(8'h34, 0, 1'b0);
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    check("midrst_data", {8'h00, I_addr, I_data}, 0);
    check("midrst_flags", {18'b0, Rx_Ready, I_wr, Cpu_Reset, Busy, Done, Error, Word_Count}, 0);
    @(negedge Clk);
    Reset    = 1'b0;
    Rx_Valid = 1'b0;
    check("midrst_drained", exp_q.size(), 0);
    build_frame(3, 1'b0, 1'b0);
    run_tx(3, 1'b1, 0, 1'b0);

    // Random frames with gaps, bad checksums and Start noise while busy.
    for (int r = 0; r < 10; r++) begin
      int  n;
      bit  bad;
      n   = $urandom_range(12, 1);
      bad = ($urandom_range(3, 0) == 0);
      build_frame(n, bad, 1'b0);
      run_tx(n, !bad, 3, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
